// File: rtl/alu_seq.sv
// alu_seq: multi-cycle WIDTH-bit 6502-style ALU. Binary ops finish one edge after start.
// Define ALU_SEQ_DECIMAL_EN to add BCD ADC/SBC, processed one nibble per edge.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             hold,
  input  logic             start,
  input  logic [3:0]       alu,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [7:0]       p_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic [7:0]       p_out
);

`ifdef ALU_SEQ_DECIMAL_EN
  typedef enum logic [1:0] {S_IDLE, S_EXE, S_DEC} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_EXE} state_t;
`endif

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [7:0]       p_q, p_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [7:0]       pin_q, pin_d;
  logic [3:0]       alu_q, alu_d;

  logic             cin;
  logic [WIDTH:0]   sum, diff, cmpd;
  logic [WIDTH-1:0] bin_r;
  logic             bin_n, bin_v, bin_z, bin_c;
  logic [7:0]       bin_p;

  always_comb begin
    cin   = pin_q[0];
    sum   = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin};
    diff  = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, ~cin};
    cmpd  = {1'b0, a_q} - {1'b0, b_q};
    bin_r = '0;
    bin_v = pin_q[6];
    bin_c = pin_q[0];
    case (alu_q)
      4'h0: bin_r = a_q | b_q;
      4'h1: bin_r = a_q & b_q;
      4'h2: bin_r = a_q ^ b_q;
      4'h3: begin
        bin_r = sum[WIDTH-1:0];
        bin_c = sum[WIDTH];
        bin_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      4'h4: bin_r = a_q;
      4'h5: bin_r = b_q;
      4'h6: begin
        bin_r = cmpd[WIDTH-1:0];
        bin_c = ~cmpd[WIDTH];
      end
      4'h7: begin
        bin_r = diff[WIDTH-1:0];
        bin_c = ~diff[WIDTH];
        bin_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      4'h8: begin
        bin_r = {b_q[WIDTH-2:0], 1'b0};
        bin_c = b_q[WIDTH-1];
      end
      4'h9: begin
        bin_r = {b_q[WIDTH-2:0], cin};
        bin_c = b_q[WIDTH-1];
      end
      4'hA: begin
        bin_r = {1'b0, b_q[WIDTH-1:1]};
        bin_c = b_q[0];
      end
      4'hB: begin
        bin_r = {cin, b_q[WIDTH-1:1]};
        bin_c = b_q[0];
      end
      4'hC: begin
        bin_r = a_q & b_q;
        bin_v = b_q[WIDTH-2];
      end
      4'hD: bin_r = b_q - WIDTH'(1);
      4'hE: bin_r = b_q + WIDTH'(1);
      default: bin_r = '0;
    endcase
    // BIT reports N from the memory operand rather than the AND result
    bin_n = (alu_q == 4'hC) ? b_q[WIDTH-1] : bin_r[WIDTH-1];
    bin_z = (bin_r == '0);
    bin_p = {bin_n, bin_v, pin_q[5:2], bin_z, bin_c};
  end

`ifdef ALU_SEQ_DECIMAL_EN
  localparam int NIB = WIDTH / 4;
  localparam int CW  = $clog2(NIB);

  logic [CW-1:0]    nib_q, nib_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [3:0]       an, bn, dnib;
  logic [4:0]       dsum, ddif;
  logic             dcarry;
  logic [WIDTH-1:0] dec_r;
  logic [7:0]       dec_p;
  logic             dec_last;

  // carry_q is the decimal carry for ADC and the decimal borrow for SBC
  always_comb begin
    an   = a_q[4*int'(nib_q) +: 4];
    bn   = b_q[4*int'(nib_q) +: 4];
    dsum = {1'b0, an} + {1'b0, bn} + {4'b0, carry_q};
    ddif = {1'b0, an} - {1'b0, bn} - {4'b0, carry_q};
    if (alu_q == 4'h7) begin
      dcarry = ddif[4];
      dnib   = ddif[4] ? (ddif[3:0] + 4'd10) : ddif[3:0];
    end else begin
      dcarry = (dsum > 5'd9);
      dnib   = (dsum > 5'd9) ? (dsum[3:0] + 4'd6) : dsum[3:0];
    end
    dec_r = acc_q;
    dec_r[4*int'(nib_q) +: 4] = dnib;
    dec_p = {dec_r[WIDTH-1], bin_v, pin_q[5:2], (dec_r == '0),
             (alu_q == 4'h7) ? ~dcarry : dcarry};
    dec_last = (nib_q == CW'(NIB - 1));
  end
`endif

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    r_d     = r_q;
    p_d     = p_q;
    a_d     = a_q;
    b_d     = b_q;
    pin_d   = pin_q;
    alu_d   = alu_q;
`ifdef ALU_SEQ_DECIMAL_EN
    nib_d   = nib_q;
    carry_d = carry_q;
    acc_d   = acc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          pin_d   = p_in;
          alu_d   = alu;
          busy_d  = 1'b1;
          state_d = S_EXE;
`ifdef ALU_SEQ_DECIMAL_EN
          if (p_in[3] && (alu == 4'h3 || alu == 4'h7)) begin
            state_d = S_DEC;
            nib_d   = '0;
            acc_d   = '0;
            carry_d = (alu == 4'h7) ? ~p_in[0] : p_in[0];
          end
`endif
        end
      end
      S_EXE: begin
        r_d     = bin_r;
        p_d     = bin_p;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
`ifdef ALU_SEQ_DECIMAL_EN
      S_DEC: begin
        acc_d   = dec_r;
        carry_d = dcarry;
        nib_d   = nib_q + CW'(1);
        if (dec_last) begin
          r_d     = dec_r;
          p_d     = dec_p;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          nib_d   = '0;
          state_d = S_IDLE;
        end
      end
`endif
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // hold acts as a clock enable: with hold low every register, done included, keeps its value
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r_q     <= '0;
      p_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      pin_q   <= '0;
      alu_q   <= '0;
`ifdef ALU_SEQ_DECIMAL_EN
      nib_q   <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
`endif
    end else if (hold) begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      r_q     <= r_d;
      p_q     <= p_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pin_q   <= pin_d;
      alu_q   <= alu_d;
`ifdef ALU_SEQ_DECIMAL_EN
      nib_q   <= nib_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
`endif
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign r     = r_q;
  assign p_out = p_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: an 8-bit and a 16-bit instance, table vectors plus
// hand-written control sequences; expectations follow ALU_SEQ_DECIMAL_EN when defined.
module tb_alu_seq;

`ifdef ALU_SEQ_DECIMAL_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif
  localparam int DEC8  = DEC_EN ? 2 : 1;
  localparam int DEC16 = DEC_EN ? 4 : 1;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        hold;
  logic        start8, start16;
  logic [3:0]  alu;
  logic [15:0] a, b;
  logic [7:0]  p_in;
  logic        busy8, done8, busy16, done16;
  logic [7:0]  r8, p8, p16;
  logic [15:0] r16;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0] f;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] p;
    logic [7:0] er;
    logic [7:0] ep;
  } vec_t;

  typedef struct {
    logic        wide;
    logic [15:0] er;
    logic [7:0]  ep;
    int          lat;
    int          start_cyc;
  } exp_t;

  vec_t vecs[18];
  exp_t sb[$];

  alu_seq #(.WIDTH(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .hold(hold), .start(start8), .alu(alu),
    .a(a[7:0]), .b(b[7:0]), .p_in(p_in),
    .busy(busy8), .done(done8), .r(r8), .p_out(p8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clock(clock), .reset_n(reset_n), .hold(hold), .start(start16), .alu(alu),
    .a(a), .b(b), .p_in(p_in),
    .busy(busy16), .done(done16), .r(r16), .p_out(p16)
  );

  // free-running clock and an edge counter used to measure latency
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // guard against a hung run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // drive one start pulse, then scramble the inputs to prove they were latched
  task automatic applyStimulus(input logic wide, input logic [3:0] f, input logic [15:0] av,
                               input logic [15:0] bv, input logic [7:0] pv,
                               input logic [15:0] er, input logic [7:0] ep, input int lat);
    exp_t e;
    @(negedge clock);
    alu = f; a = av; b = bv; p_in = pv;
    if (wide) start16 = 1'b1;
    else start8 = 1'b1;
    @(posedge clock);
    #1;
    start8 = 1'b0; start16 = 1'b0;
    a = 16'($urandom); b = 16'($urandom); p_in = 8'($urandom); alu = 4'($urandom);
    e.wide = wide; e.er = er; e.ep = ep; e.lat = lat; e.start_cyc = cyc;
    sb.push_back(e);
  endtask

  // wait (bounded) for done, then compare against the oldest scoreboard entry
  task automatic checkOutput(input string name, input bit check_drop);
    exp_t e;
    int n;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("[TB] FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    n = 0;
    while (!(e.wide ? done16 : done8) && n < 40) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (!(e.wide ? done16 : done8)) begin
      checks++; errors++;
      $display("[TB] FAIL %s timeout: done=0, expected done=1", name);
      return;
    end
    check({name, " r"}, e.wide ? r16 : {8'h00, r8}, e.er);
    check({name, " p"}, {8'h00, e.wide ? p16 : p8}, {8'h00, e.ep});
    check({name, " latency"}, 16'(cyc - e.start_cyc), 16'(e.lat));
    check({name, " busy at done"}, {15'b0, e.wide ? busy16 : busy8}, 16'h0);
    if (check_drop) begin
      @(posedge clock);
      #1;
      check({name, " done drop"}, {15'b0, e.wide ? done16 : done8}, 16'h0);
    end
  endtask

  initial begin
    vecs[0]  = '{4'h0, 8'h0F, 8'hF0, 8'h20, 8'hFF, 8'hA0};
    vecs[1]  = '{4'h1, 8'h0F, 8'hF0, 8'h21, 8'h00, 8'h23};
    vecs[2]  = '{4'h2, 8'hFF, 8'h0F, 8'h60, 8'hF0, 8'hE0};
    vecs[3]  = '{4'h4, 8'h00, 8'h55, 8'h20, 8'h00, 8'h22};
    vecs[4]  = '{4'h5, 8'h00, 8'h81, 8'h20, 8'h81, 8'hA0};
    vecs[5]  = '{4'h6, 8'h10, 8'h20, 8'h21, 8'hF0, 8'hA0};
    vecs[6]  = '{4'h7, 8'h50, 8'hB0, 8'h21, 8'hA0, 8'hE0};
    vecs[7]  = '{4'h8, 8'h00, 8'h81, 8'h20, 8'h02, 8'h21};
    vecs[8]  = '{4'h9, 8'h00, 8'h80, 8'h21, 8'h01, 8'h21};
    vecs[9]  = '{4'hA, 8'h00, 8'h01, 8'h20, 8'h00, 8'h23};
    vecs[10] = '{4'hB, 8'h00, 8'h01, 8'h21, 8'h80, 8'hA1};
    vecs[11] = '{4'hC, 8'h01, 8'hC0, 8'h21, 8'h00, 8'hE3};
    vecs[12] = '{4'hD, 8'h00, 8'h00, 8'h20, 8'hFF, 8'hA0};
    vecs[13] = '{4'hE, 8'h00, 8'hFF, 8'h21, 8'h00, 8'h23};
    vecs[14] = '{4'hF, 8'h12, 8'h34, 8'hFD, 8'h00, 8'h7F};
    vecs[15] = '{4'h3, 8'hFF, 8'h00, 8'h21, 8'h00, 8'h23};
    vecs[16] = '{4'h3, 8'h01, 8'h01, 8'h34, 8'h02, 8'h34};
    vecs[17] = '{4'h3, 8'h7F, 8'h80, 8'h20, 8'hFF, 8'hA0};

    reset_n = 1'b0; hold = 1'b1; start8 = 1'b0; start16 = 1'b0;
    alu = 4'h0; a = 16'h0; b = 16'h0; p_in = 8'h0;
    repeat (2) @(posedge clock);
    #1;
    check("reset busy", {15'b0, busy8}, 16'h0);
    check("reset done", {15'b0, done8}, 16'h0);
    check("reset r", {8'h00, r8}, 16'h0);
    check("reset p", {8'h00, p8}, 16'h0);
    check("reset r16", r16, 16'h0);
    @(negedge clock);
    reset_n = 1'b1;

    applyStimulus(1'b0, 4'h3, 16'h50, 16'h50, 8'h20, 16'h00A0, 8'hE0, 1);
    check("adc busy", {15'b0, busy8}, 16'h1);
    checkOutput("adc 50+50", 1'b1);

    // back-to-back: each start lands in the cycle where the previous done is high
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1'b0, vecs[i].f, {8'h00, vecs[i].a}, {8'h00, vecs[i].b}, vecs[i].p,
                    {8'h00, vecs[i].er}, vecs[i].ep, 1);
      checkOutput($sformatf("vec%0d", i), 1'b0);
    end

    applyStimulus(1'b0, 4'h3, 16'h58, 16'h46, 8'h28,
                  DEC_EN ? 16'h0004 : 16'h009E, DEC_EN ? 8'h69 : 8'hE8, DEC8);
    check("dadc busy", {15'b0, busy8}, 16'h1);
    checkOutput("dadc 58+46", 1'b1);
    applyStimulus(1'b0, 4'h7, 16'h46, 16'h12, 8'h29, 16'h0034, 8'h29, DEC8);
    checkOutput("dsbc 46-12", 1'b0);
    applyStimulus(1'b0, 4'h7, 16'h12, 16'h21, 8'h29,
                  DEC_EN ? 16'h0091 : 16'h00F1, 8'hA8, DEC8);
    checkOutput("dsbc 12-21", 1'b1);

    applyStimulus(1'b1, 4'h3, 16'h0999, 16'h0001, 8'h28,
                  DEC_EN ? 16'h1000 : 16'h099A, 8'h28, DEC16);
    checkOutput("w16 dadc", 1'b1);
    applyStimulus(1'b1, 4'h3, 16'h7FFF, 16'h0001, 8'h20, 16'h8000, 8'hE0, 1);
    checkOutput("w16 adc", 1'b1);

    // a second start while busy must be ignored
    applyStimulus(1'b0, 4'h3, 16'h58, 16'h46, 8'h28,
                  DEC_EN ? 16'h0004 : 16'h009E, DEC_EN ? 8'h69 : 8'hE8, DEC8);
    @(negedge clock);
    alu = 4'h0; a = 16'h11; b = 16'h11; p_in = 8'h20; start8 = 1'b1;
    @(posedge clock);
    #1;
    start8 = 1'b0;
    checkOutput("repulse", 1'b1);
    begin
      int pulses;
      pulses = 0;
      repeat (4) begin
        @(posedge clock);
        #1;
        if (done8 || busy8) pulses++;
      end
      check("repulse ignored", 16'(pulses), 16'h0);
    end

    // hold low for three edges right after start stretches latency by three
    applyStimulus(1'b0, 4'h3, 16'h58, 16'h46, 8'h28,
                  DEC_EN ? 16'h0004 : 16'h009E, DEC_EN ? 8'h69 : 8'hE8, DEC8 + 3);
    hold = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    hold = 1'b1;
    checkOutput("hold stretch", 1'b0);
    hold = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("hold freezes done", {15'b0, done8}, 16'h1);
    hold = 1'b1;
    @(posedge clock);
    #1;
    check("done after hold", {15'b0, done8}, 16'h0);

    // asynchronous reset in the middle of an operation
    applyStimulus(1'b0, 4'h3, 16'h58, 16'h46, 8'h28, 16'h0, 8'h0, DEC8);
    void'(sb.pop_front());
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset busy", {15'b0, busy8}, 16'h0);
    check("midreset done", {15'b0, done8}, 16'h0);
    check("midreset r", {8'h00, r8}, 16'h0);
    check("midreset p", {8'h00, p8}, 16'h0);
    @(negedge clock);
    reset_n = 1'b1;
    applyStimulus(1'b0, 4'h7, 16'h12, 16'h21, 8'h29,
                  DEC_EN ? 16'h0091 : 16'h00F1, 8'hA8, DEC8);
    checkOutput("after reset", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the CPU core's inline combinational ALU.
- Same 4-bit function codes and 6502 flag semantics, generalised to WIDTH bits.
- Adds BCD (decimal-mode) ADC/SBC, processed one nibble per clock.
- Sits beside the core's EXEC stage; the core starts an operation and stalls until done.

Parameters:
WIDTH, 8, operand/result width in bits; multiple of 4, minimum 8
NIB, WIDTH/4, nibble count (derived, not overridable)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
hold  in  1  clock enable; 0 freezes all state (same meaning as the core's hold)
start  in  1  begin operation; sampled only in IDLE with hold=1
alu  in  4  function code: 0 ORA, 1 AND, 2 EOR, 3 ADC, 4 pass a, 5 pass b, 6 CMP, 7 SBC, 8 ASL, 9 ROL, A LSR, B ROR, C BIT, D DEC, E INC, F invalid
a  in  WIDTH  left operand (accumulator/index)
b  in  WIDTH  right operand (memory/immediate)
p_in  in  8  flags NV-BDIZC at start
busy  out  1  operation in progress
done  out  1  one-cycle pulse, result valid
r  out  WIDTH  registered result
p_out  out  8  registered flags

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. reset_n=0 forces the following immediately: state=IDLE, busy=0, done=0, r=0, p_out=0, nibble counter=0, internal carry=0.
- Operand latching: at the start edge, a, b, p_in and alu are latched. Later input changes have no effect on the running operation.
- States: IDLE, EXE, DEC.
  - IDLE: start=1 and hold=1 -> latch operands, busy=1. Go to DEC if p_in[3]=1 and alu is 3 or 7 (decimal); otherwise go to EXE.
  - EXE: one edge. r and p_out are written, done=1, busy=0, then return to IDLE.
  - DEC: one nibble per edge, starting with the low nibble. After NIB edges, r and p_out are written, done=1, busy=0, then return to IDLE.
- Latency, with start sampled at edge k:
  - binary: done high after edge k+1;
  - decimal: done high after edge k+NIB.
- done: high for exactly one cycle; it deasserts on the next enabled edge.
- start while busy: ignored.
- start in the same cycle as done: accepted, because the FSM is already in IDLE.
- hold=0: everything freezes, including done, which stays high until the next enabled edge.
- Binary arithmetic, all at WIDTH bits; cin=p_in[0]:
  - ADC: a+b+cin, C = carry out of bit WIDTH-1.
  - SBC: a-b-!cin, C = NOT borrow.
  - CMP: a-b, C = NOT borrow, r = difference.
  - DEC/INC: b-1 / b+1, wrapping.
  - Shifts act on b:
    - ASL/ROL: C = b[W-1], rotate-in for ROL = cin.
    - LSR/ROR: C = b[0], rotate-in for ROR = cin, placed at the MSB.
- Flags:
  - N = r[W-1] and Z = (r==0) for all ops except BIT.
  - V changes only for ADC, SBC and BIT:
    - ADC V = (a[W-1]==b[W-1]) & (r[W-1]!=a[W-1]);
    - SBC V = (a[W-1]!=b[W-1]) & (r[W-1]!=a[W-1]).
  - BIT: N = b[W-1], V = b[W-2], Z = ((a&b)==0), r = a&b, C unchanged.
  - C unchanged for logic, pass, DEC and INC.
  - p_out bits 5..2 always copy p_in.
- Code F: r=0, Z=1, N=0, all other flags unchanged.
- Decimal ADC, per nibble: s = an+bn+c. If s>9 then s+=6 and c=1, else c=0. The result nibble is s[3:0]. Initial c=cin.
- Decimal SBC, per nibble: d = an-bn-borrow. If d<0 then d+=10 and borrow=1. Initial borrow=!cin. Final C = !borrow.
- Decimal flags: N and Z from the BCD result. V from the binary computation of the same operands. Non-BCD input digits: the same nibble rules apply with no error indication; the result is defined by those rules.

Optional Feature:
- Macro: ALU_SEQ_DECIMAL_EN.
- Defined: DEC state and nibble datapath are present, behaving as above.
- Undefined: DEC state is absent and p_in[3] is ignored. ADC/SBC always take the binary EXE path with 1-edge latency. p_out[3] still copies p_in[3].

Test Plan:
- WIDTH=8, binary ADC a=0x50 b=0x50 p_in=0x20 -> after edge k+1: done=1, r=0xA0, N=1, V=1, Z=0, C=0; done=0 one cycle later.
- WIDTH=8, decimal ADC a=0x58 b=0x46 p_in=0x28 (D=1, C=0) -> done after edge k+2, r=0x04, C=1; busy=1 for exactly 2 cycles.
- WIDTH=8, decimal SBC a=0x46 b=0x12 p_in=0x29 -> r=0x34, C=1. Then SBC a=0x12 b=0x21 p_in=0x29 -> r=0x91, C=0.
- WIDTH=16, decimal ADC a=0x0999 b=0x0001 p_in=0x28 -> done after edge k+4, r=0x1000, C=0, Z=0.
- WIDTH=8: CMP a=0x10 b=0x20 -> r=0xF0, C=0, N=1. BIT a=0x01 b=0xC0 -> N=1, V=1, Z=1, C unchanged. ROR b=0x01 cin=1 -> r=0x80, C=1.
- Control: start re-pulsed during DEC is ignored. hold=0 for 3 cycles mid-DEC extends latency by 3. reset_n low mid-DEC -> busy=0, done=0, r=0, p_out=0 immediately, with a later clean start working normally.
